soc_system_clk_gen: RTL
=======================

// Module: soc_system_clk_gen
// PURPOSE
//  Programmable clock/tick generator consuming the 1-bit enable from the clk_HPS PIO output.
//  Sits directly downstream of that PIO; out_port wires to enable_in.
//  Produces a glitch-free divided square wave clk_out plus a 1-cycle tick on each clk_out rise.
//  Own Avalon-MM slave (zero-wait, combinational readdata) for divisor, status and edge count.
// PARAMETERS
//  DIV_W        16   width of divisor / half-period counter
//  DEFAULT_DIV  50   reset value of DIVISOR (half-period, in clk cycles)
// PORTS
//  clk         in   1      system clock; single clock domain
//  reset_n     in   1      asynchronous, active-low reset
//  enable_in   in   1      run request, from PIO out_port
//  address     in   2      Avalon word address
//  chipselect  in   1      Avalon select
//  write_n     in   1      Avalon write strobe, active-low
//  writedata   in   32     Avalon write data
//  readdata    out  32     Avalon read data, combinational from address
//  clk_out     out  1      divided clock (registered)
//  tick        out  1      1-cycle pulse coincident with clk_out 0->1
// BEHAVIOUR
//  Reset: DIVISOR=DEFAULT_DIV, div_act=DEFAULT_DIV, cnt=0, EDGES=0, state=IDLE, clk_out=0, tick=0.
//  Register map (write = chipselect & ~write_n):
//   0 DIVISOR  RW  bits[DIV_W-1:0]; upper bits read 0.
//   1 STATUS   RO  {28'b0, state[1:0], clk_out, busy}; busy = (state!=IDLE).
//   2 EDGES    RW  32-bit rising-edge count, wraps 0xFFFFFFFF->0; any write clears to 0.
//   3 reserved reads 0, writes ignored.
//  Effective half = (div_act==0) ? 1 : div_act. div_act loads from DIVISOR on IDLE->RUN and
//   on each clk_out rise; DIVISOR writes never shorten/stretch a half-period in progress.
//  FSM (en = enable_in, or its synchronised copy with macro):
//   IDLE : clk_out=0, cnt=0. en=1 -> RUN (load div_act).
//   RUN  : cnt++; at cnt==half-1: cnt=0, clk_out toggles; rise => tick=1, EDGES++.
//          en=0 -> STOP.
//   STOP : if clk_out=0 -> IDLE next cycle; else keep counting, at terminal count drive
//          clk_out=0 and go IDLE. en=1 while in STOP -> RUN, cnt/clk_out undisturbed.
//  Latency: en seen high in cycle N -> RUN at N+1; first clk_out rise at edge N+1+half.
//  clk_out never produces a high pulse shorter than half clk cycles (glitch-free stop).
//  EDGES: write-clear and tick in same cycle -> EDGES=0 (clear wins).
//  DIVISOR write during STOP: takes effect on next RUN entry or rise.
//  Reset asserted mid-operation: all state returns to reset values immediately (async).
// CONFIGURATION
//  SOC_CLK_GEN_SYNC_EN defined: enable_in passes a 2-flop synchroniser (reset 0); enable
//   latency +2 cycles. Undefined: enable_in used directly (same-clock PIO source).
// STRUCTURE
//  Package soc_clk_gen_pkg: state enum {IDLE=2'd0, RUN=2'd1, STOP=2'd2}, register address
//   constants ADDR_DIVISOR/ADDR_STATUS/ADDR_EDGES, STATUS bit positions.
//  One sub-module soc_clk_gen_divider: cnt, div_act, clk_out, tick given run/stop controls;
//   top holds Avalon regs, FSM, EDGES counter, optional synchroniser.
// TESTING
//  1 Reset, read addr0/1/2 -> 50, 0x0, 0x0; clk_out=0, tick=0.
//  2 DIVISOR=3, enable_in=1 -> clk_out period 6 clks, 50% duty; tick once per rise;
//    after 4 rises EDGES reads 4.
//  3 DIVISOR=5, drop enable_in 2 clks into high phase -> clk_out stays high 5 clks total,
//    falls, STATUS busy=0 next cycle; no extra tick.
//  4 DIVISOR=0 -> treated as 1: clk_out toggles every cycle (period 2).
//  5 Write DIVISOR 4->8 mid high phase -> current phases keep 4; from next rise phases are 8.
//  6 Write addr2 on a tick cycle -> EDGES reads 0; preload via 0xFFFFFFFF rises shows wrap to 0.

Source files
------------

// File: rtl/soc_clk_gen_pkg.sv
// soc_clk_gen_pkg
//   Shared definitions for the programmable clock/tick generator:
//   FSM state encoding, Avalon register addresses, STATUS bit layout
//   and a helper that packs the STATUS word.
package soc_clk_gen_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } clk_gen_state_e;

    // Plain-vector copies of the state codes for code that keeps state in logic.
    localparam logic [1:0] ST_IDLE = 2'(IDLE);
    localparam logic [1:0] ST_RUN  = 2'(RUN);
    localparam logic [1:0] ST_STOP = 2'(STOP);

    localparam logic [1:0] ADDR_DIVISOR = 2'd0;
    localparam logic [1:0] ADDR_STATUS  = 2'd1;
    localparam logic [1:0] ADDR_EDGES   = 2'd2;

    localparam int STATUS_BUSY_BIT  = 0;
    localparam int STATUS_CLK_BIT   = 1;
    localparam int STATUS_STATE_LSB = 2;

    function automatic logic [31:0] pack_status(input logic [1:0] st, input logic clk_lvl);
        logic [31:0] w;
        w = '0;
        w[STATUS_BUSY_BIT]                      = (st != ST_IDLE);
        w[STATUS_CLK_BIT]                       = clk_lvl;
        w[STATUS_STATE_LSB+1:STATUS_STATE_LSB]  = st;
        return w;
    endfunction

endpackage

// File: rtl/soc_system_clk_gen_if.sv
// soc_system_clk_gen_if
//   Avalon-MM register port of the clock generator (zero-wait slave).
//   address[1:0], chipselect, write_n (active-low), writedata[31:0] : master -> slave
//   readdata[31:0]                                                  : slave -> master
interface soc_system_clk_gen_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (output address, chipselect, write_n, writedata, input readdata);
    modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/soc_clk_gen_divider.sv
// soc_clk_gen_divider
//   Half-period counter and registered divided clock.
//   Ports:
//     clk, reset_n   clock, async active-low reset
//     clear          force cnt=0, clk_out=0
//     load           capture divisor into div_act
//     advance        count one cycle; toggle clk_out at terminal count
//     divisor        programmed half-period (0 behaves as 1)
//     clk_out        divided clock
//     tick           1-cycle pulse coincident with clk_out rising
//     rise_now       combinational: clk_out rises at the coming edge
//     term           combinational: cnt is at terminal count
module soc_clk_gen_divider #(
    parameter int DIV_W       = 16,
    parameter int DEFAULT_DIV = 50
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             load,
    input  logic             advance,
    input  logic [DIV_W-1:0] divisor,
    output logic             clk_out,
    output logic             tick,
    output logic             rise_now,
    output logic             term
);
    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] div_act;
    logic [DIV_W-1:0] last_cnt;

    always_comb begin
        last_cnt = (div_act == '0) ? '0 : div_act - DIV_W'(1);
        term     = (cnt == last_cnt);
        rise_now = advance & term & ~clk_out;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt     <= '0;
            div_act <= DIV_W'(DEFAULT_DIV);
            clk_out <= 1'b0;
            tick    <= 1'b0;
        end else begin
            tick <= rise_now;
            if (clear) begin
                cnt     <= '0;
                clk_out <= 1'b0;
            end else if (advance) begin
                if (term) begin
                    cnt     <= '0;
                    clk_out <= ~clk_out;
                end else begin
                    cnt <= cnt + DIV_W'(1);
                end
            end
            // The active half-period only changes at a period boundary so a
            // register write never reshapes a phase already under way.
            if (load || rise_now) begin
                div_act <= divisor;
            end
        end
    end
endmodule

// File: rtl/soc_system_clk_gen.sv
// soc_system_clk_gen
//   Programmable clock/tick generator driven by the clk_HPS PIO enable.
//   Ports:
//     clk, reset_n   system clock, async active-low reset
//     enable_in      run request from PIO out_port
//     avs            Avalon-MM slave (DIVISOR, STATUS, EDGES)
//     clk_out        glitch-free divided clock
//     tick           1-cycle pulse on each clk_out rise
//   Build option: SOC_CLK_GEN_SYNC_EN adds a 2-flop synchroniser on enable_in.
//
//   state | meaning
//   IDLE  | clk_out held low, counter cleared, waiting for enable
//   RUN   | dividing; clk_out toggles every half-period
//   STOP  | enable dropped; finish the high phase, then go idle
module soc_system_clk_gen
    import soc_clk_gen_pkg::*;
#(
    parameter int DIV_W       = 16,
    parameter int DEFAULT_DIV = 50
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  enable_in,
    soc_system_clk_gen_if.slave   avs,
    output logic                  clk_out,
    output logic                  tick
);
    logic             en;
    logic [1:0]       state, state_nxt;
    logic             div_clear, div_load, div_adv;
    logic             rise_now, term;
    logic [DIV_W-1:0] divisor;
    logic [31:0]      edges;
    logic             wr;

`ifdef SOC_CLK_GEN_SYNC_EN
    logic en_meta, en_sync;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            en_meta <= 1'b0;
            en_sync <= 1'b0;
        end else begin
            en_meta <= enable_in;
            en_sync <= en_meta;
        end
    end
    assign en = en_sync;
`else
    assign en = enable_in;
`endif

    always_comb begin
        state_nxt = state;
        div_clear = 1'b0;
        div_load  = 1'b0;
        div_adv   = 1'b0;
        case (state)
            ST_IDLE: begin
                div_clear = 1'b1;
                if (en) begin
                    state_nxt = ST_RUN;
                    div_load  = 1'b1;
                end
            end
            ST_RUN: begin
                div_adv = 1'b1;
                if (!en) state_nxt = ST_STOP;
            end
            ST_STOP: begin
                if (en) begin
                    div_adv   = 1'b1;
                    state_nxt = ST_RUN;
                end else if (!clk_out) begin
                    div_clear = 1'b1;
                    state_nxt = ST_IDLE;
                end else begin
                    // High phase runs to full length; the terminal toggle is the fall.
                    div_adv = 1'b1;
                    if (term) state_nxt = ST_IDLE;
                end
            end
            default: begin
                div_clear = 1'b1;
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign wr = avs.chipselect & ~avs.write_n;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ST_IDLE;
            divisor <= DIV_W'(DEFAULT_DIV);
            edges   <= '0;
        end else begin
            state <= state_nxt;
            if (wr && avs.address == ADDR_DIVISOR) begin
                divisor <= avs.writedata[DIV_W-1:0];
            end
            // A clearing write beats a coincident rise.
            if (wr && avs.address == ADDR_EDGES) begin
                edges <= '0;
            end else if (rise_now) begin
                edges <= edges + 32'd1;
            end
        end
    end

    always_comb begin
        avs.readdata = '0;
        case (avs.address)
            ADDR_DIVISOR: avs.readdata[DIV_W-1:0] = divisor;
            ADDR_STATUS:  avs.readdata = pack_status(state, clk_out);
            ADDR_EDGES:   avs.readdata = edges;
            default:      avs.readdata = '0;
        endcase
    end

    soc_clk_gen_divider #(
        .DIV_W       (DIV_W),
        .DEFAULT_DIV (DEFAULT_DIV)
    ) u_divider (
        .clk      (clk),
        .reset_n  (reset_n),
        .clear    (div_clear),
        .load     (div_load),
        .advance  (div_adv),
        .divisor  (divisor),
        .clk_out  (clk_out),
        .tick     (tick),
        .rise_now (rise_now),
        .term     (term)
    );
endmodule
